// File: rtl/fetch_pkg.sv
// Shared fetch-stage types for the branch prediction unit: branch types,
// 2-bit counter encoding, per-slot prediction and resolution records.
package fetch_pkg;

  localparam int XLEN          = 64;
  localparam int OFFSET        = 2;  // instructions are 4-byte aligned
  localparam int BPU_HLEN      = 4;  // GHR width carried in resolution records
  localparam int BPU_RAS_DEPTH = 4;  // RAS depth carried in resolution records
  localparam int RAS_PTR_W     = (BPU_RAS_DEPTH > 1) ? $clog2(BPU_RAS_DEPTH) : 1;

  // 2-bit saturating counter states; MSB set means predict taken
  typedef enum logic [1:0] {SNT = 2'b00, WNT = 2'b01, WT = 2'b10, ST = 2'b11} c2b_t;

  typedef enum logic [1:0] {BR = 2'b00, JMP = 2'b01, CALL = 2'b10, RET = 2'b11} btype_t;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic            hit;
    logic            taken;
    logic [XLEN-1:0] target;
    btype_t          btype;
  } bpu_pred_t;

  typedef struct packed {
    logic [XLEN-1:0]      pc;
    logic [XLEN-1:0]      target;
    logic                 taken;
    logic                 mispredict;
    btype_t               btype;
    logic [BPU_HLEN-1:0]  ghr;
    logic [RAS_PTR_W-1:0] ras_ptr;
  } bpu_res_t;

  // Saturating counter step toward the resolved direction
  function automatic logic [1:0] c2b_update(input logic [1:0] c, input logic taken);
    if (taken) return (c == 2'b11) ? c : c + 2'd1;
    else       return (c == 2'b00) ? c : c - 2'd1;
  endfunction

endpackage

// File: rtl/bpu_ras_ras.sv
// Circular return-address stack. The pointer addresses the next free slot;
// count saturates at DEPTH so a push when full overwrites the oldest entry.
// A restore reloads the pointer from a checkpoint (with a +/-1 adjustment)
// and takes priority over push/pop in the same cycle.
module bpu_ras_ras
  import fetch_pkg::*;
#(
  parameter int DEPTH = 4,
  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  localparam int CNT_W = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             push,
  input  logic             pop,
  input  logic [XLEN-1:0]  push_addr,
  input  logic             restore,
  input  logic [PTR_W-1:0] restore_ptr,
  input  logic             restore_inc,
  input  logic             restore_dec,
  output logic [XLEN-1:0]  top,
  output logic [PTR_W-1:0] ptr,
  output logic             empty
);

  logic [XLEN-1:0]  stack_mem [DEPTH];
  logic [PTR_W-1:0] ptr_reg, ptr_next;
  logic [CNT_W-1:0] cnt_reg, cnt_next;

  // Next pointer/count: restore wins over the speculative push/pop
  always_comb begin
    ptr_next = ptr_reg;
    cnt_next = cnt_reg;
    if (restore) begin
      ptr_next = restore_ptr;
      if (restore_inc) begin
        ptr_next = restore_ptr + PTR_W'(1);
        if (cnt_reg != CNT_W'(DEPTH)) cnt_next = cnt_reg + CNT_W'(1);
      end else if (restore_dec) begin
        ptr_next = restore_ptr - PTR_W'(1);
        if (cnt_reg != '0) cnt_next = cnt_reg - CNT_W'(1);
      end
    end else if (push) begin
      ptr_next = ptr_reg + PTR_W'(1);
      if (cnt_reg != CNT_W'(DEPTH)) cnt_next = cnt_reg + CNT_W'(1);
    end else if (pop && cnt_reg != '0) begin
      ptr_next = ptr_reg - PTR_W'(1);
      cnt_next = cnt_reg - CNT_W'(1);
    end
  end

  // Pointer and occupancy registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr_reg <= '0;
      cnt_reg <= '0;
    end else if (flush) begin
      ptr_reg <= '0;
      cnt_reg <= '0;
    end else begin
      ptr_reg <= ptr_next;
      cnt_reg <= cnt_next;
    end
  end

  // Entry storage; contents are only read while count is non-zero
  always_ff @(posedge clk) begin
    if (push && !restore && !flush) stack_mem[ptr_reg] <= push_addr;
  end

  assign top   = stack_mem[ptr_reg - PTR_W'(1)];
  assign ptr   = ptr_reg;
  assign empty = (cnt_reg == '0);

endmodule

// File: rtl/bpu_ras.sv
// Branch prediction unit: gshare PHT + typed direct-mapped BTB + speculative
// GHR with recovery + circular RAS, predicting NSLOT slots per fetch packet.
// Lookup is combinational; speculative state advances on fetch_ready_i and
// is overridden by mispredict recovery, which is overridden by flush_i.
// Optional build macro LEN5_BPU_STATS_EN adds lookup/mispredict counters.
module bpu_ras
  import fetch_pkg::*;
#(
  parameter int   NSLOT     = 2,
  parameter int   HLEN      = BPU_HLEN,
  parameter int   BTB_BITS  = 4,
  parameter int   RAS_DEPTH = BPU_RAS_DEPTH,
  parameter c2b_t INIT_C2B  = WNT,
  localparam int  SLOT_BITS = $clog2(NSLOT),
  localparam int  SLOT_W    = (SLOT_BITS > 0) ? SLOT_BITS : 1,
  localparam int  RPW       = (RAS_DEPTH > 1) ? $clog2(RAS_DEPTH) : 1
) (
  input  logic                        clk_i,
  input  logic                        rst_ni,
  input  logic                        flush_i,
  input  logic [XLEN-1:0]             curr_pc_i,
  input  logic                        fetch_ready_i,
  input  logic                        res_valid_i,
  input  bpu_res_t                    res_i,
  output bpu_pred_t [NSLOT-1:0]       pred_o,
  output logic                        pred_taken_o,
  output logic [SLOT_W-1:0]           pred_slot_o,
  output logic [HLEN-1:0]             pred_ghr_o,
  output logic [RPW-1:0]              pred_ras_ptr_o
`ifdef LEN5_BPU_STATS_EN
  ,
  output logic [31:0]                 lookups_o,
  output logic [31:0]                 mispredicts_o
`endif
);

  localparam int TAG_W = XLEN - OFFSET - BTB_BITS;
  localparam int TGT_W = XLEN - OFFSET;
  localparam int BTB_N = 1 << BTB_BITS;
  localparam int PHT_N = 1 << HLEN;

  logic [BTB_N-1:0] btb_valid_reg;
  logic [TAG_W-1:0] btb_tag_mem  [BTB_N];
  logic [TGT_W-1:0] btb_tgt_mem  [BTB_N];
  btype_t           btb_type_mem [BTB_N];
  logic [1:0]       pht_reg      [PHT_N];
  logic [HLEN-1:0]  ghr_reg, ghr_next;

  logic [XLEN-1:0]  slot_pc   [NSLOT];
  btype_t           slot_type [NSLOT];
  logic [NSLOT-1:0] slot_hit, slot_taken;

  logic [XLEN-1:0]  ras_top;
  logic [RPW-1:0]   ras_ptr;
  logic             ras_empty;

  logic             upd_hit, upd_taken;
  btype_t           upd_type;
  logic [XLEN-1:0]  upd_ret_addr;

  logic             recover;
  logic [HLEN-1:0]  res_ghr;
  logic [BTB_BITS-1:0] res_bidx;
  logic [HLEN-1:0]  res_pidx;

  assign recover  = res_valid_i && res_i.mispredict;
  assign res_ghr  = HLEN'(res_i.ghr);
  assign res_bidx = res_i.pc[OFFSET +: BTB_BITS];
  assign res_pidx = res_i.pc[OFFSET +: HLEN] ^ res_ghr;

  // Per-slot BTB/PHT lookup
  generate
    for (genvar gi = 0; gi < NSLOT; gi++) begin : g_slot
      logic [BTB_BITS-1:0] bidx;
      logic [HLEN-1:0]     pidx;
      logic [XLEN-1:0]     tgt;

      assign slot_pc[gi] = {curr_pc_i[XLEN-1:OFFSET+SLOT_BITS], {(OFFSET+SLOT_BITS){1'b0}}}
                         | (XLEN'(gi) << OFFSET);
      assign bidx          = slot_pc[gi][OFFSET +: BTB_BITS];
      assign pidx          = slot_pc[gi][OFFSET +: HLEN] ^ ghr_reg;
      assign slot_type[gi] = btb_type_mem[bidx];
      assign slot_hit[gi]  = btb_valid_reg[bidx] && (btb_tag_mem[bidx] == slot_pc[gi][XLEN-1 -: TAG_W]);
      assign slot_taken[gi] = slot_hit[gi] && ((slot_type[gi] != BR) || pht_reg[pidx][1]);
      // Returns use the RAS top when it holds something, else the BTB target
      assign tgt = (slot_type[gi] == RET && !ras_empty) ? ras_top
                                                       : {btb_tgt_mem[bidx], {OFFSET{1'b0}}};
      assign pred_o[gi] = '{pc: slot_pc[gi], hit: slot_hit[gi], taken: slot_taken[gi],
                            target: tgt, btype: slot_type[gi]};
    end
  endgenerate

  // First taken slot for redirect; first hit slot drives the speculative update
  always_comb begin
    pred_slot_o  = '0;
    upd_hit      = 1'b0;
    upd_taken    = 1'b0;
    upd_type     = BR;
    upd_ret_addr = '0;
    for (int i = NSLOT - 1; i >= 0; i--) begin
      if (slot_taken[i]) pred_slot_o = SLOT_W'(i);
      if (slot_hit[i]) begin
        upd_hit      = 1'b1;
        upd_taken    = slot_taken[i];
        upd_type     = slot_type[i];
        upd_ret_addr = slot_pc[i] + XLEN'(4);
      end
    end
  end

  assign pred_taken_o   = |slot_taken;
  assign pred_ghr_o     = ghr_reg;
  assign pred_ras_ptr_o = ras_ptr;

  // GHR next value: recovery beats speculative shift
  always_comb begin
    ghr_next = ghr_reg;
    if (recover) begin
      ghr_next = (res_i.btype == BR) ? {res_ghr[HLEN-2:0], res_i.taken} : res_ghr;
    end else if (fetch_ready_i && upd_hit && upd_type == BR) begin
      ghr_next = {ghr_reg[HLEN-2:0], upd_taken};
    end
  end

  // GHR register
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni)      ghr_reg <= '0;
    else if (flush_i) ghr_reg <= '0;
    else              ghr_reg <= ghr_next;
  end

  // PHT counters trained by resolutions
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < PHT_N; i++) pht_reg[i] <= INIT_C2B;
    end else if (flush_i) begin
      for (int i = 0; i < PHT_N; i++) pht_reg[i] <= INIT_C2B;
    end else if (res_valid_i) begin
      pht_reg[res_pidx] <= c2b_update(pht_reg[res_pidx], res_i.taken);
    end
  end

  // BTB valid bits: set on taken, cleared on mispredicted not-taken
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      btb_valid_reg <= '0;
    end else if (flush_i) begin
      btb_valid_reg <= '0;
    end else if (res_valid_i) begin
      if (res_i.taken)           btb_valid_reg[res_bidx] <= 1'b1;
      else if (res_i.mispredict) btb_valid_reg[res_bidx] <= 1'b0;
    end
  end

  // BTB payload, written for every taken resolution
  always_ff @(posedge clk_i) begin
    if (res_valid_i && res_i.taken) begin
      btb_tag_mem[res_bidx]  <= res_i.pc[XLEN-1 -: TAG_W];
      btb_tgt_mem[res_bidx]  <= res_i.target[XLEN-1:OFFSET];
      btb_type_mem[res_bidx] <= res_i.btype;
    end
  end

  bpu_ras_ras #(
    .DEPTH (RAS_DEPTH)
  ) u_ras (
    .clk         (clk_i),
    .rst_n       (rst_ni),
    .flush       (flush_i),
    .push        (fetch_ready_i && upd_hit && upd_type == CALL),
    .pop         (fetch_ready_i && upd_hit && upd_type == RET),
    .push_addr   (upd_ret_addr),
    .restore     (recover),
    .restore_ptr (RPW'(res_i.ras_ptr)),
    .restore_inc (res_i.btype == CALL),
    .restore_dec (res_i.btype == RET),
    .top         (ras_top),
    .ptr         (ras_ptr),
    .empty       (ras_empty)
  );

  logic unused_bits;
  assign unused_bits = ^{curr_pc_i[OFFSET+SLOT_BITS-1:0], res_i.target[OFFSET-1:0]};

`ifdef LEN5_BPU_STATS_EN
  logic [31:0] lookups_reg, mispredicts_reg;

  // Wrapping event counters
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      lookups_reg     <= '0;
      mispredicts_reg <= '0;
    end else if (flush_i) begin
      lookups_reg     <= '0;
      mispredicts_reg <= '0;
    end else begin
      if (fetch_ready_i) lookups_reg     <= lookups_reg + 32'd1;
      if (recover)       mispredicts_reg <= mispredicts_reg + 32'd1;
    end
  end

  assign lookups_o     = lookups_reg;
  assign mispredicts_o = mispredicts_reg;
`endif

endmodule

// File: tb/tb_bpu_ras.sv
// Scoreboard bench for bpu_ras: stimulus pushes expected observations into a
// queue, a negedge monitor pops and compares against the live outputs.
module tb_bpu_ras;
  import fetch_pkg::*;

  logic                  clk = 1'b0;
  logic                  rst_ni = 1'b1;
  logic                  flush_i = 1'b0;
  logic [XLEN-1:0]       curr_pc_i = '0;
  logic                  fetch_ready_i = 1'b0;
  logic                  res_valid_i = 1'b0;
  bpu_res_t              res_i = '0;
  bpu_pred_t [1:0]       pred_o;
  logic                  pred_taken_o;
  logic [0:0]            pred_slot_o;
  logic [3:0]            pred_ghr_o;
  logic [1:0]            pred_ras_ptr_o;

  always #5 clk = ~clk;

  bpu_ras dut (
    .clk_i          (clk),
    .rst_ni         (rst_ni),
    .flush_i        (flush_i),
    .curr_pc_i      (curr_pc_i),
    .fetch_ready_i  (fetch_ready_i),
    .res_valid_i    (res_valid_i),
    .res_i          (res_i),
    .pred_o         (pred_o),
    .pred_taken_o   (pred_taken_o),
    .pred_slot_o    (pred_slot_o),
    .pred_ghr_o     (pred_ghr_o),
    .pred_ras_ptr_o (pred_ras_ptr_o)
  );

  typedef enum int {K_HIT, K_TAKEN, K_TGT, K_PTAKEN, K_PSLOT, K_GHR, K_RPTR} kind_t;
  typedef struct {
    string       name;
    kind_t       kind;
    int          slot;
    logic [63:0] val;
  } exp_t;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_pass   = 0;

  function automatic logic [63:0] actual(kind_t k, int s);
    case (k)
      K_HIT:    return 64'(pred_o[s].hit);
      K_TAKEN:  return 64'(pred_o[s].taken);
      K_TGT:    return pred_o[s].target;
      K_PTAKEN: return 64'(pred_taken_o);
      K_PSLOT:  return 64'(pred_slot_o);
      K_GHR:    return 64'(pred_ghr_o);
      default:  return 64'(pred_ras_ptr_o);
    endcase
  endfunction

  // Monitor: drain every expectation queued for this cycle
  always @(negedge clk) begin
    while (sb.size() > 0) begin
      exp_t e;
      logic [63:0] a;
      e = sb.pop_front();
      a = actual(e.kind, e.slot);
      n_checks++;
      if (a === e.val) n_pass++;
      else $display("FAIL %s: got 0x%0h, expected 0x%0h", e.name, a, e.val);
    end
  end

  task automatic ex(input string name, input kind_t k, input int s, input logic [63:0] v);
    exp_t e;
    e.name = name; e.kind = k; e.slot = s; e.val = v;
    sb.push_back(e);
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic do_flush();
    cyc();
    res_valid_i = 1'b0; fetch_ready_i = 1'b0; flush_i = 1'b1;
    $display("flush");
  endtask

  task automatic resolve(input logic [63:0] pc, input logic [63:0] tgt, input logic tk,
                         input logic mp, input btype_t bt, input logic [3:0] g, input logic [1:0] rp);
    cyc();
    flush_i = 1'b0; fetch_ready_i = 1'b0; res_valid_i = 1'b1;
    res_i = '{pc: pc, target: tgt, taken: tk, mispredict: mp, btype: bt, ghr: g, ras_ptr: rp};
    $display("resolve pc=0x%0h tgt=0x%0h taken=%0b mispredict=%0b type=%s", pc, tgt, tk, mp, bt.name());
  endtask

  task automatic lookup(input logic [63:0] pc, input logic fr);
    cyc();
    flush_i = 1'b0; res_valid_i = 1'b0; curr_pc_i = pc; fetch_ready_i = fr;
    $display("lookup pc=0x%0h fetch_ready=%0b", pc, fr);
  endtask

  logic [63:0] ret_tgt [5] = '{64'h202C, 64'h2024, 64'h201C, 64'h2014, 64'h900};
  int          ret_ptr [5] = '{1, 0, 3, 2, 1};
  int          call_ptr [5] = '{0, 1, 2, 3, 0};
  logic [3:0]  ghr_seq [4] = '{4'h0, 4'h1, 4'h2, 4'h5};
  logic        tk_seq  [4] = '{1'b1, 1'b0, 1'b1, 1'b1};

  initial begin
    #1 rst_ni = 1'b0;
    #11 rst_ni = 1'b1;

    // Reset state
    lookup(64'h100, 1'b0);
    ex("reset_hit0", K_HIT, 0, 0);
    ex("reset_hit1", K_HIT, 1, 0);
    ex("reset_ptaken", K_PTAKEN, 0, 0);
    ex("reset_ghr", K_GHR, 0, 0);
    ex("reset_rptr", K_RPTR, 0, 0);

    // Branch trained taken twice from WNT
    resolve(64'h100, 64'h200, 1'b1, 1'b0, BR, 4'h0, 2'd0);
    resolve(64'h100, 64'h200, 1'b1, 1'b0, BR, 4'h0, 2'd0);
    lookup(64'h100, 1'b0);
    ex("br_hit", K_HIT, 0, 1);
    ex("br_taken", K_TAKEN, 0, 1);
    ex("br_tgt", K_TGT, 0, 64'h200);
    ex("br_ptaken", K_PTAKEN, 0, 1);
    ex("br_pslot", K_PSLOT, 0, 0);

    // Taken branch in slot 1 only
    resolve(64'h10C, 64'h300, 1'b1, 1'b0, BR, 4'h0, 2'd0);
    resolve(64'h10C, 64'h300, 1'b1, 1'b0, BR, 4'h0, 2'd0);
    lookup(64'h108, 1'b0);
    ex("s1_hit0", K_HIT, 0, 0);
    ex("s1_hit1", K_HIT, 1, 1);
    ex("s1_tgt1", K_TGT, 1, 64'h300);
    ex("s1_pslot", K_PSLOT, 0, 1);
    ex("s1_ptaken", K_PTAKEN, 0, 1);

    // Call then return
    resolve(64'h400, 64'h1000, 1'b1, 1'b0, CALL, 4'h0, 2'd0);
    lookup(64'h400, 1'b1);
    ex("call_hit", K_HIT, 0, 1);
    ex("call_tgt", K_TGT, 0, 64'h1000);
    ex("call_rptr", K_RPTR, 0, 0);
    resolve(64'h800, 64'h0, 1'b1, 1'b0, RET, 4'h0, 2'd0);
    lookup(64'h800, 1'b0);
    ex("ret_hit", K_HIT, 0, 1);
    ex("ret_taken", K_TAKEN, 0, 1);
    ex("ret_tgt", K_TGT, 0, 64'h404);
    ex("ret_rptr", K_RPTR, 0, 1);
    ex("ret_ghr", K_GHR, 0, 0);

    // Flush clears BTB and RAS, then RAS overflow / underflow
    do_flush();
    lookup(64'h800, 1'b0);
    ex("flush1_hit", K_HIT, 0, 0);
    ex("flush1_rptr", K_RPTR, 0, 0);
    for (int k = 0; k < 5; k++)
      resolve(64'h2008 + 64'(8 * k), 64'h3000, 1'b1, 1'b0, CALL, 4'h0, 2'd0);
    resolve(64'h800, 64'h900, 1'b1, 1'b0, RET, 4'h0, 2'd0);
    for (int k = 0; k < 5; k++) begin
      lookup(64'h2008 + 64'(8 * k), 1'b1);
      ex($sformatf("call%0d_ptaken", k), K_PTAKEN, 0, 1);
      ex($sformatf("call%0d_rptr", k), K_RPTR, 0, 64'(call_ptr[k]));
    end
    for (int k = 0; k < 5; k++) begin
      lookup(64'h800, 1'b1);
      ex($sformatf("pop%0d_tgt", k), K_TGT, 0, ret_tgt[k]);
      ex($sformatf("pop%0d_rptr", k), K_RPTR, 0, 64'(ret_ptr[k]));
    end
    lookup(64'h800, 1'b0);
    ex("underflow_rptr", K_RPTR, 0, 1);

    // Speculative GHR build-up to 0b1011
    do_flush();
    resolve(64'h4000, 64'h5000, 1'b1, 1'b0, BR, 4'h0, 2'd0);
    resolve(64'h4000, 64'h5000, 1'b1, 1'b0, BR, 4'h2, 2'd0);
    resolve(64'h4000, 64'h5000, 1'b1, 1'b0, BR, 4'h5, 2'd0);
    for (int k = 0; k < 4; k++) begin
      lookup(64'h4000, 1'b1);
      ex($sformatf("spec%0d_ghr", k), K_GHR, 0, 64'(ghr_seq[k]));
      ex($sformatf("spec%0d_taken", k), K_TAKEN, 0, 64'(tk_seq[k]));
    end

    // Mispredict not-taken alongside an accepted fetch
    cyc();
    curr_pc_i = 64'h4000; fetch_ready_i = 1'b1; res_valid_i = 1'b1; flush_i = 1'b0;
    res_i = '{pc: 64'h4000, target: 64'h5000, taken: 1'b0, mispredict: 1'b1,
              btype: BR, ghr: 4'h2, ras_ptr: 2'd0};
    $display("mispredict pc=0x4000 with concurrent fetch");
    ex("pre_recover_ghr", K_GHR, 0, 64'hB);
    lookup(64'h4000, 1'b0);
    ex("recover_ghr", K_GHR, 0, 64'h4);
    ex("recover_hit", K_HIT, 0, 0);

    // Flush restores PHT to INIT_C2B
    do_flush();
    lookup(64'h4000, 1'b0);
    ex("flush2_ghr", K_GHR, 0, 0);
    ex("flush2_rptr", K_RPTR, 0, 0);
    resolve(64'h4000, 64'h6000, 1'b1, 1'b0, BR, 4'hF, 2'd0);
    lookup(64'h4000, 1'b0);
    ex("flush2_hit", K_HIT, 0, 1);
    ex("flush2_pht_taken", K_TAKEN, 0, 0);
    ex("flush2_tgt", K_TGT, 0, 64'h6000);
    ex("flush2_ptaken", K_PTAKEN, 0, 0);

    cyc();
    fetch_ready_i = 1'b0; res_valid_i = 1'b0; flush_i = 1'b0;
    @(negedge clk);
    @(negedge clk);
    #1;
    if (sb.size() != 0) begin
      $display("FAIL drain: got %0d unchecked entries, expected 0", sb.size());
      n_checks = n_checks + sb.size();
    end
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/bpu_ras.md
Name: bpu_ras

Overview:
Second-generation branch prediction unit for the LEN5 fetch stage. It extends the current gshare plus BTB predictor in four ways: a true speculative global history register (GHR) with recovery, NSLOT fetch slots per lookup, typed BTB entries (branch/jump/call/ret), and a circular return-address stack (RAS) with pointer checkpointing. It sits between the PC generator and the fetch unit and is updated by branch-unit resolutions.

Parameters:
NSLOT, 2, instructions per fetch packet (power of 2, 1..4)
HLEN, 4, GHR length and PHT index width (PHT = 2^HLEN 2-bit counters)
BTB_BITS, 4, BTB index width (2^BTB_BITS direct-mapped entries)
RAS_DEPTH, 4, RAS entries (power of 2, >=2)
INIT_C2B, fetch_pkg::WNT, PHT counter value at reset and on flush

Ports:
clk_i  in  1  clock
rst_ni  in  1  asynchronous active-low reset
flush_i  in  1  synchronous clear of all predictor state
curr_pc_i  in  XLEN  fetch-packet PC
fetch_ready_i  in  1  fetch accepts current prediction; speculative state advances
res_valid_i  in  1  resolution valid
res_i  in  bpu_res_t  {pc, target, taken, mispredict, btype, ghr, ras_ptr}
pred_o  out  NSLOT x bpu_pred_t  per slot {pc, hit, taken, target, btype}
pred_taken_o  out  1  some slot predicted taken
pred_slot_o  out  log2(NSLOT) (min 1)  first taken slot
pred_ghr_o  out  HLEN  GHR snapshot for this packet
pred_ras_ptr_o  out  log2(RAS_DEPTH)  RAS top pointer snapshot

Behaviour:
- Reset (async) and flush_i (sync): BTB valid bits = 0, PHT = INIT_C2B, GHR = 0, RAS ptr = 0, count = 0. Outputs are combinational from this state, so all hit/taken = 0.
- Lookup is combinational (0 latency). Slot i pc = {curr_pc_i[XLEN-1:OFFSET+log2 NSLOT], i, OFFSET'b0}.
- BTB entry = {valid, tag = pc[XLEN-1:OFFSET+BTB_BITS], target[XLEN-1:OFFSET], btype}.
- hit = valid & tag match. PHT index = pc[HLEN+OFFSET-1:OFFSET] XOR GHR.
- Slot taken when hit and either (btype = branch and counter MSB = 1) or btype is jump, call or ret.
- pred_slot_o = lowest taken slot. Slots above it are reported but ignored downstream.
- Target is {btb target, OFFSET'b0}. For ret with RAS count > 0, target = RAS[ptr-1].
- Speculative update on fetch_ready_i, applied at the posedge, first taken-or-branch slot only:
  - Conditional branch (first hit conditional at or before pred_slot): GHR <= {GHR[HLEN-2:0], taken}.
  - Call: push slot pc+4 at ptr; ptr++ (wrap); count = min(count+1, RAS_DEPTH). When full, the push overwrites the oldest entry.
  - Ret: if count > 0 then ptr-- (wrap), count--. When empty, no change and target falls back to the BTB.
- Resolution (res_valid_i):
  - PHT[res.pc ^ res.ghr]: saturating increment if taken, decrement otherwise.
  - BTB write of {tag, target, btype} when taken.
  - BTB invalidate when mispredict & ~taken.
- Recovery on res_valid_i & mispredict:
  - GHR <= {res.ghr[HLEN-2:0], res.taken} for btype = branch; otherwise GHR <= res.ghr.
  - RAS ptr <= res.ras_ptr, adjusted +1 for a mispredicted call or -1 for a ret. count is not restored; it saturates at 0..RAS_DEPTH.
  - Recovery overrides the same-cycle speculative update.
- Priority: flush_i > mispredict recovery > speculative update. PHT/BTB resolution writes still occur alongside a speculative update.
- Same-cycle read/write of one entry: the read returns the old value.

Optional Feature:
LEN5_BPU_STATS_EN:
- With it: adds 32-bit outputs lookups_o (incremented on fetch_ready_i) and mispredicts_o (incremented on res_valid_i & mispredict). Both wrap, and are cleared by reset and flush.
- Without it: these ports and counters do not exist.

Decomposition:
- fetch_pkg: btype_t (BR, JMP, CALL, RET), bpu_pred_t, bpu_res_t, and RAS_PTR_W derived from RAS_DEPTH.
- Sub-module: ras (circular stack with push/pop/restore ports). PHT, BTB and GHR stay inline.

Test Plan:
- Reset, then any PC -> all hit = 0, taken = 0, pred_ghr_o = 0.
- Resolve branch pc 0x100 taken twice, target 0x200 (WNT start) -> lookup 0x100 gives hit = 1, taken = 1, target 0x200.
- Call at 0x400 (BTB btype CALL) accepted, then ret at 0x800 (BTB RET, target 0x0) -> ret target = 0x404.
- 5 calls with RAS_DEPTH = 4, then 5 rets -> first 4 pop the newest addresses in reverse order; the 5th uses the BTB target.
- Speculative GHR 0b1011, then mispredict with res.ghr = 0b0010, taken = 0 -> GHR = 0b0100 next cycle, and the same-cycle fetch update is discarded.
- Mispredict not-taken on a BTB entry -> hit = 0 next cycle; flush_i -> PHT reads INIT_C2B and RAS is empty.
